// File: rtl/score_argmax_reader_pkg.sv
// Shared sizing and state encoding for the score argmax reader.
package score_argmax_reader_pkg;

  localparam int DEFAULT_N          = 10;
  localparam int DEFAULT_VALUE_SIZE = 26;

  function automatic int calc_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int DEFAULT_IDX_W = calc_idx_w(DEFAULT_N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/score_argmax_reader.sv
// Accepts a packed score vector, scans it one element per cycle and
// returns the lowest-index maximum, its value and a tie flag.
module score_argmax_reader
  import score_argmax_reader_pkg::*;
#(
  parameter int N          = DEFAULT_N,
  parameter int VALUE_SIZE = DEFAULT_VALUE_SIZE,
  parameter int IDX_W      = calc_idx_w(N)
) (
  input  logic                    clk,
  input  logic                    GlobalReset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*VALUE_SIZE-1:0] values,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDX_W-1:0]        class_idx,
  output logic [VALUE_SIZE-1:0]   class_value,
  output logic                    out_tie,
  output logic                    busy
);

  // One extra bit so a power-of-two N cannot wrap before the last compare.
  localparam int               CNT_W    = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  state_e                         state_q, state_d;
  logic [N*VALUE_SIZE-1:0]        buf_q, buf_d;
  logic signed [VALUE_SIZE-1:0]   best_val_q, best_val_d;
  logic [IDX_W-1:0]               best_idx_q, best_idx_d;
  logic                           tie_q, tie_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic signed [VALUE_SIZE-1:0]   cur_score;
  logic                           accept;
  logic                           scan_done;

  assign accept    = in_valid && (state_q == IDLE);
  assign scan_done = (cnt_q == LAST_CNT);

  always_comb begin
    cur_score = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CNT_W'(i)) cur_score = buf_q[i*VALUE_SIZE +: VALUE_SIZE];
    end
  end

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      best_val_q <= '0;
      best_idx_q <= '0;
      tie_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
      tie_q      <= tie_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (N == 1) ? HOLD : SCAN;
      SCAN:    if (scan_done) state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == HOLD);
    busy      = (state_q != IDLE);
  end

  // Equal scores keep the earlier index and only raise the tie flag.
  always_comb begin
    buf_d      = buf_q;
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    tie_d      = tie_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          buf_d      = values;
          best_val_d = values[VALUE_SIZE-1:0];
          best_idx_d = '0;
          tie_d      = 1'b0;
          cnt_d      = CNT_W'(1);
        end
      end
      SCAN: begin
        if (cur_score > best_val_q) begin
          best_val_d = cur_score;
          best_idx_d = cnt_q[IDX_W-1:0];
          tie_d      = 1'b0;
        end else if (cur_score == best_val_q) begin
          tie_d = 1'b1;
        end
        cnt_d = cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  assign class_idx   = best_idx_q;
  assign class_value = best_val_q;
  assign out_tie     = tie_q;

endmodule

// File: tb/tb_score_argmax_reader.sv
// Randomised and directed bench for score_argmax_reader at N=10, N=1 and N=16.
module tb_score_argmax_reader;

  localparam int VS = 26;
  typedef logic signed [VS-1:0] score_t;
  typedef score_t vec_t [16];

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  logic             a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_tie, a_busy;
  logic [10*VS-1:0] a_values;
  logic [3:0]       a_idx;
  logic [VS-1:0]    a_val;

  logic             b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_tie, b_busy;
  logic [VS-1:0]    b_values;
  logic [0:0]       b_idx;
  logic [VS-1:0]    b_val;

  logic             c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_tie, c_busy;
  logic [16*VS-1:0] c_values;
  logic [3:0]       c_idx;
  logic [VS-1:0]    c_val;

  score_argmax_reader #(.N(10), .VALUE_SIZE(VS), .IDX_W(4)) dut_a (
    .clk(clk), .GlobalReset(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .values(a_values), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .class_idx(a_idx), .class_value(a_val), .out_tie(a_tie), .busy(a_busy));

  score_argmax_reader #(.N(1), .VALUE_SIZE(VS), .IDX_W(1)) dut_b (
    .clk(clk), .GlobalReset(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .values(b_values), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .class_idx(b_idx), .class_value(b_val), .out_tie(b_tie), .busy(b_busy));

  score_argmax_reader #(.N(16), .VALUE_SIZE(VS), .IDX_W(4)) dut_c (
    .clk(clk), .GlobalReset(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .values(c_values), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .class_idx(c_idx), .class_value(c_val), .out_tie(c_tie), .busy(c_busy));

  // Reference: global maximum, first index holding it, tie if held more than once.
  function automatic void model(input vec_t s, input int n, output int idx,
                                output score_t mx, output bit tie);
    int hits = 0;
    mx = s[0];
    for (int i = 1; i < n; i++) if (s[i] > mx) mx = s[i];
    idx = -1;
    for (int i = 0; i < n; i++) begin
      if (s[i] == mx) begin
        if (idx < 0) idx = i;
        hits++;
      end
    end
    tie = (hits > 1);
  endfunction

  task automatic a_accept(input vec_t s);
    int k = 0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) a_values[i*VS +: VS] = s[i];
    a_in_valid = 1'b1;
    while (!a_in_ready && k < 100) begin @(negedge clk); k++; end
    checks++;
    if (a_in_ready !== 1'b1) begin
      failures++; $display("FAIL accept_wait in_ready=%0b required=1", a_in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    for (int i = 0; i < 10; i++) a_values[i*VS +: VS] = VS'($urandom);
  endtask

  task automatic a_wait_check(input vec_t s, input string name);
    int lat = 0;
    int eidx;
    score_t ev;
    bit et;
    model(s, 10, eidx, ev, et);
    while (!a_out_valid && lat < 100) begin @(posedge clk); @(negedge clk); lat++; end
    checks++;
    if (lat != 9) begin failures++; $display("FAIL %s latency=%0d required=9", name, lat); end
    checks++;
    if (a_idx !== 4'(eidx)) begin failures++; $display("FAIL %s idx=%0d required=%0d", name, a_idx, eidx); end
    checks++;
    if (a_val !== ev) begin failures++; $display("FAIL %s value=%h required=%h", name, a_val, ev); end
    checks++;
    if (a_tie !== et) begin failures++; $display("FAIL %s tie=%0b required=%0b", name, a_tie, et); end
  endtask

  task automatic a_pop(input string name);
    a_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_out_ready = 1'b0;
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_release out_valid=%0b in_ready=%0b required 0/1", name, a_out_valid, a_in_ready);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_in_ready, a_out_valid, a_busy, a_tie} !== 4'b1000 || a_idx !== 4'd0 || a_val !== '0) begin
      failures++;
      $display("FAIL reset rdy/vld/busy/tie=%b idx=%0d val=%h required 1000/0/0", {a_in_ready, a_out_valid, a_busy, a_tie}, a_idx, a_val);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    vec_t s = '{default: '0};
    int init [10] = '{5, -3, 17, 2, 17, 0, -100, 16, 1, 4};
    for (int i = 0; i < 10; i++) s[i] = score_t'(init[i]);
    a_out_ready = 1'b1;
    a_accept(s);
    checks++;
    if (a_busy !== 1'b1) begin failures++; $display("FAIL basic_busy busy=%0b required=1", a_busy); end
    a_wait_check(s, "basic");
    a_pop("basic");
  endtask

  task automatic test_all_negative;
    vec_t s = '{default: '0};
    int init [10] = '{-50, -7, -9, -7, -1000, -8, -20, -30, -40, -60};
    for (int i = 0; i < 10; i++) s[i] = score_t'(init[i]);
    a_accept(s);
    a_wait_check(s, "negative_tie");
    a_pop("negative_tie");
    s[1] = score_t'(-6);
    a_accept(s);
    a_wait_check(s, "negative_single");
    a_pop("negative_single");
  endtask

  task automatic test_extremes;
    vec_t s = '{default: score_t'(26'h2000000)};
    s[9] = score_t'(26'h1FFFFFF);
    a_accept(s);
    a_wait_check(s, "extremes");
    checks++;
    if (a_idx !== 4'd9) begin failures++; $display("FAIL extremes_idx idx=%0d required=9", a_idx); end
    a_pop("extremes");
  endtask

  task automatic test_reset_mid;
    vec_t s = '{default: '0};
    int init [10] = '{5, -3, 17, 2, 17, 0, -100, 16, 1, 4};
    int seen = 0;
    for (int i = 0; i < 10; i++) s[i] = score_t'(init[i]);
    a_accept(s);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_in_ready, a_out_valid, a_busy, a_tie} !== 4'b1000 || a_idx !== 4'd0 || a_val !== '0) begin
      failures++;
      $display("FAIL reset_mid rdy/vld/busy/tie=%b idx=%0d val=%h required 1000/0/0", {a_in_ready, a_out_valid, a_busy, a_tie}, a_idx, a_val);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (a_out_valid || !a_in_ready) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL reset_mid_quiet bad_cycles=%0d required=0", seen); end
  endtask

  task automatic test_backpressure;
    vec_t sa = '{default: '0};
    vec_t sb = '{default: '0};
    int eidx;
    score_t ev;
    bit et;
    int bad = 0;
    for (int i = 0; i < 10; i++) begin
      sa[i] = score_t'(int'($urandom_range(0, 200)) - 100);
      sb[i] = score_t'(int'($urandom_range(0, 200)) - 100);
    end
    model(sa, 10, eidx, ev, et);
    a_accept(sa);
    a_wait_check(sa, "bp_first");
    for (int i = 0; i < 10; i++) a_values[i*VS +: VS] = sb[i];
    a_in_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_idx !== 4'(eidx) || a_val !== ev || a_tie !== et) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL bp_hold unstable_cycles=%0d required=0", bad); end
    a_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_out_ready = 1'b0;
    checks++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      failures++; $display("FAIL bp_idle in_ready=%0b out_valid=%0b required 1/0", a_in_ready, a_out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    checks++;
    if (a_busy !== 1'b1) begin failures++; $display("FAIL bp_second_accept busy=%0b required=1", a_busy); end
    a_wait_check(sb, "bp_second");
    a_pop("bp_second");
  endtask

  task automatic test_random;
    vec_t s = '{default: '0};
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 10; i++) begin
        if (it % 3 == 0) s[i] = score_t'($urandom);
        else s[i] = score_t'(int'($urandom_range(0, 15)) - 8);
      end
      if (it % 7 == 3) s[$urandom_range(0, 9)] = score_t'(26'h2000000);
      a_accept(s);
      a_wait_check(s, "random");
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a_pop("random");
    end
  endtask

  task automatic test_n1;
    @(negedge clk);
    b_values = VS'(-5);
    b_in_valid = 1'b1;
    checks++;
    if (b_in_ready !== 1'b1) begin failures++; $display("FAIL n1_ready in_ready=%0b required=1", b_in_ready); end
    @(posedge clk);
    @(negedge clk);
    b_in_valid = 1'b0;
    b_values = '0;
    checks++;
    if (b_out_valid !== 1'b1 || b_idx !== 1'b0 || b_val !== VS'(-5) || b_tie !== 1'b0) begin
      failures++;
      $display("FAIL n1_result vld=%0b idx=%0d val=%h tie=%0b required 1/0/%h/0", b_out_valid, b_idx, b_val, b_tie, VS'(-5));
    end
    b_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_out_ready = 1'b0;
    checks++;
    if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
      failures++; $display("FAIL n1_release in_ready=%0b out_valid=%0b required 1/0", b_in_ready, b_out_valid);
    end
  endtask

  task automatic test_n16;
    vec_t s = '{default: '0};
    int eidx;
    score_t ev;
    bit et;
    for (int it = 0; it < 6; it++) begin
      int lat = 0;
      int k = 0;
      for (int i = 0; i < 16; i++) s[i] = score_t'(int'($urandom_range(0, 1000)) - 500);
      if (it == 0) s[15] = score_t'(1000);
      model(s, 16, eidx, ev, et);
      @(negedge clk);
      for (int i = 0; i < 16; i++) c_values[i*VS +: VS] = s[i];
      c_in_valid = 1'b1;
      while (!c_in_ready && k < 100) begin @(negedge clk); k++; end
      @(posedge clk);
      @(negedge clk);
      c_in_valid = 1'b0;
      c_values = '0;
      while (!c_out_valid && lat < 100) begin @(posedge clk); @(negedge clk); lat++; end
      checks++;
      if (lat != 15) begin failures++; $display("FAIL n16_latency latency=%0d required=15", lat); end
      checks++;
      if (c_idx !== 4'(eidx) || c_val !== ev || c_tie !== et) begin
        failures++;
        $display("FAIL n16_result idx=%0d val=%h tie=%0b required %0d/%h/%0b", c_idx, c_val, c_tie, eidx, ev, et);
      end
      if (it == 0) begin
        checks++;
        if (c_idx !== 4'd15) begin failures++; $display("FAIL n16_last_idx idx=%0d required=15", c_idx); end
      end
      c_out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      c_out_ready = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_values = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_values = '0;
    c_in_valid = 1'b0; c_out_ready = 1'b0; c_values = '0;
    test_reset;
    test_basic;
    test_all_negative;
    test_extremes;
    test_reset_mid;
    test_backpressure;
    test_random;
    test_n1;
    test_n16;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/score_argmax_reader.md
Name: score_argmax_reader

Overview:
- Consumer end of the vector-matrix product datapath.
- Accepts the packed vector of N signed class scores with a valid/ready handshake and scans it sequentially, one score per cycle.
- Returns the winning class index and its score through a second valid/ready handshake.
- Sits between the vector-matrix product stage and the classification result / readout logic.

Parameters:
N, 10, number of class scores (columns of the weight matrix); legal range 1..64
VALUE_SIZE, 26, width of each signed two's-complement score
IDX_W, 4, width of the class index; must equal max(1, ceil(log2(N)))

Ports:
clk  input  1  clock; all state updates on rising edge
GlobalReset  input  1  asynchronous, active-low reset
in_valid  input  1  score vector present on values
in_ready  output  1  block can accept a vector (high only in IDLE)
values  input  N*VALUE_SIZE  packed scores; score i = values[(i+1)*VALUE_SIZE-1 : i*VALUE_SIZE]
out_valid  output  1  result valid and held stable
out_ready  input  1  downstream accepts the result
class_idx  output  IDX_W  index of the maximum score
class_value  output  VALUE_SIZE  the maximum score (signed)
out_tie  output  1  another index carried a score equal to the final maximum
busy  output  1  high in SCAN or HOLD

Behaviour:
- Reset (GlobalReset low, asynchronous):
  - state = IDLE; in_ready = 1.
  - out_valid, busy, out_tie, class_idx, class_value, scan counter and captured vector all = 0.
  - Takes effect immediately, including mid-SCAN or mid-HOLD; the in-flight vector is discarded and no out_valid is produced for it.
- States: IDLE, SCAN, HOLD. in_ready = (state == IDLE); out_valid = (state == HOLD); busy = (state != IDLE).
- IDLE:
  - On in_valid & in_ready, register the whole values bus into an internal buffer.
  - Initialise best_value = score0, best_idx = 0, tie = 0, cnt = 1.
  - Go to SCAN; if N == 1, go directly to HOLD.
  - values is sampled only at the accept edge; later changes on values are ignored.
- SCAN (one element per cycle):
  - Compare buffered score[cnt] against best_value as signed VALUE_SIZE quantities.
  - If strictly greater: best_value = score[cnt], best_idx = cnt, tie = 0.
  - If equal: tie = 1, and best_idx is unchanged (lowest index wins).
  - If less: no change.
  - cnt increments; after processing cnt == N-1, go to HOLD.
- Latency:
  - Accept edge at cycle t; out_valid rises after edge t+N-1 (N-1 scan cycles).
  - With N = 10, out_valid is high 9 cycles after the accept edge.
  - Throughput is one vector per N cycles plus the output handshake.
- HOLD:
  - class_idx, class_value and out_tie are stable and driven from registers.
  - On out_ready, return to IDLE; in_ready rises the following cycle, so there is no same-cycle re-accept.
  - out_ready while not in HOLD is ignored.
  - Output registers keep their last values in IDLE; only out_valid qualifies them.
- Arithmetic:
  - Comparisons are signed.
  - Most negative value 0x2000000 (26-bit) is less than every other value.
  - No saturation is needed (compare only).
- Counter: IDX_W+1 bits internally so that N equal to a power of two does not wrap before termination.
- Simultaneous events: in_valid during SCAN or HOLD is not accepted (in_ready is low); the upstream producer holds it.

Decomposition:
- Shared package holds:
  - default N and VALUE_SIZE, shared with the vector-matrix product stage;
  - IDX_W computed from N;
  - state enum {IDLE, SCAN, HOLD}.
- Single module; no sub-module is natural. The signed compare-and-update is a few lines inside the SCAN branch.

Test Plan:
- Reset mid-op: accept a vector, pull GlobalReset low during SCAN at cnt=4 -> all outputs 0 immediately, in_ready=1 after release, no out_valid for that vector.
- Basic: N=10, scores 0..9 = {5,-3,17,2,17,0,-100,16,1,4}, out_ready held high -> out_valid 9 cycles after accept, class_idx=2, class_value=17, out_tie=1, then IDLE next cycle.
- All negative: scores {-50,-7,-9,-7,-1000,-8,-20,-30,-40,-60} -> class_idx=1, class_value=-7, out_tie=1. Same vector with score1 = -6 -> class_idx=1, value=-6, tie=0.
- Extremes: score9 = 0x1FFFFFF, all others = 0x2000000 -> class_idx=9, class_value=0x1FFFFFF, tie=0 (checks signed compare and last-element handling).
- Backpressure: keep out_ready low for 20 cycles in HOLD while in_valid is high with a new vector -> outputs stable, in_ready=0, second vector not taken. Release out_ready -> second vector accepted one cycle later, and its result is correct.
- Parameter sweep: N=1 with score0 = -5 -> out_valid the cycle after accept, idx=0. N=16, IDX_W=4, maximum at index 15 -> class_idx=15.
